// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter that time-shares one fixed-latency floating-point multiplier
// among NUM_REQ requesters, returning each product to the requester that issued it.
module fp_mult_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LATENCY = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]     i_req_a,
  input  logic [NUM_REQ*WIDTH-1:0]     i_req_b,
  output logic [NUM_REQ-1:0]           o_req_ready,
  output logic [NUM_REQ-1:0]           o_resp_valid,
  output logic [WIDTH-1:0]             o_resp_data,
  input  logic [NUM_REQ-1:0]           i_resp_ready,
  output logic [WIDTH-1:0]             o_mul_a,
  output logic [WIDTH-1:0]             o_mul_b,
  input  logic [WIDTH-1:0]             i_mul_res,
  output logic [$clog2(NUM_REQ)-1:0]   o_grant_id,
  output logic                         o_busy
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned CW  = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     grant_q, grant_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic [WIDTH-1:0]   resp_data_q, resp_data_d;
  logic               resp_valid_q, resp_valid_d;

  logic               win_found_c;
  logic [IDW-1:0]     win_c;
  logic [IDW-1:0]     cand_c;
  logic [NUM_REQ-1:0] req_ready_c;
  logic               hs_c;

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    win_found_c = 1'b0;
    win_c       = ptr_q;
    cand_c      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand_c = IDW'((32'(ptr_q) + i) % NUM_REQ);
      if (!win_found_c && i_req_valid[cand_c]) begin
        win_found_c = 1'b1;
        win_c       = cand_c;
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = resp_valid_q;
    req_ready_c  = '0;
    hs_c         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (win_found_c && !i_rst) begin
          req_ready_c[win_c] = 1'b1;
        end
        hs_c = i_req_valid[win_c] & req_ready_c[win_c];
        if (hs_c) begin
          mul_a_d = i_req_a[32'(win_c)*WIDTH +: WIDTH];
          mul_b_d = i_req_b[32'(win_c)*WIDTH +: WIDTH];
          grant_d = win_c;
          cnt_d   = CW'(LATENCY);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          resp_data_d  = i_mul_res;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (i_resp_ready[grant_q]) begin
          resp_valid_d = 1'b0;
          ptr_d        = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + IDW'(1);
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      cnt_q        <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Handshake flags are forced low while reset is held, even mid-transaction.
  always_comb begin
    o_resp_valid = '0;
    if (resp_valid_q && !i_rst) begin
      o_resp_valid[grant_q] = 1'b1;
    end
  end

  assign o_req_ready = req_ready_c;
  assign o_busy      = (state_q != ST_IDLE) && !i_rst;
  assign o_resp_data = resp_data_q;
  assign o_mul_a     = mul_a_q;
  assign o_mul_b     = mul_b_q;
  assign o_grant_id  = grant_q;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Randomized self-checking bench for fp_mult_arbiter with a pipelined behavioural
// multiplier and a transaction-level round-robin reference model.
module tb_fp_mult_arbiter;

  localparam int W = 32;
  localparam int N = 4;
  localparam int L = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid, req_ready, resp_valid, resp_ready;
  logic [N*W-1:0]   req_a, req_b;
  logic [W-1:0]     resp_data, mul_a, mul_b, mul_res;
  logic [1:0]       grant_id;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Requester-side view: what each requester currently presents.
  logic [W-1:0] va [N];
  logic [W-1:0] vb [N];
  logic [N-1:0] vv;
  int           ptr;

  always #5 clk = ~clk;

  fp_mult_arbiter #(.WIDTH(W), .NUM_REQ(N), .LATENCY(L)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .i_req_a(req_a), .i_req_b(req_b),
    .o_req_ready(req_ready), .o_resp_valid(resp_valid), .o_resp_data(resp_data),
    .i_resp_ready(resp_ready),
    .o_mul_a(mul_a), .o_mul_b(mul_b), .i_mul_res(mul_res),
    .o_grant_id(grant_id), .o_busy(busy)
  );

  // Truncating single-precision multiply for normal operands; NaNs propagate as-is.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    int          e;
    logic        s;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF && a[22:0] != 23'd0) return a;
    if (b[30:23] == 8'hFF && b[22:0] != 23'd0) return b;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) return {s, 8'(e + 1), p[46:24]};
    return {s, 8'(e), p[45:23]};
  endfunction

  // Fixed-latency multiplier: result valid LATENCY-1 edges after operands settle.
  logic [W-1:0] pipe [L-1];
  initial for (int i = 0; i < L-1; i++) pipe[i] = '0;
  always @(posedge clk) begin
    pipe[0] <= fmul(mul_a, mul_b);
    for (int i = 1; i < L-1; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_res = pipe[L-2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_fp();
    return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  task automatic apply();
    req_valid = vv;
    for (int k = 0; k < N; k++) begin
      req_a[k*W +: W] = va[k];
      req_b[k*W +: W] = vb[k];
    end
  endtask

  function automatic int rr_pick();
    for (int i = 0; i < N; i++) begin
      if (vv[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  // One transaction, entered and left at posedge+1 of an IDLE cycle.
  // after: 0 drop request, 1 keep same operands, 2 keep with new operands.
  task automatic run_txn(input int hold, input int after, input bit churn,
                         output logic [W-1:0] got);
    int           g, cyc;
    bit           seen;
    logic [W-1:0] ea, eb;
    got = '0;
    g = rr_pick();
    if (g < 0) begin
      check("model_no_requester", 1, 0);
      return;
    end
    ea = va[g];
    eb = vb[g];
    @(negedge clk);
    check("req_ready", 64'(req_ready), 64'(1 << g));
    check("busy_idle", 64'(busy), 0);
    @(posedge clk); #1;
    check("busy_wait", 64'(busy), 1);
    check("grant_id", 64'(grant_id), 64'(g));
    check("mul_a", 64'(mul_a), 64'(ea));
    check("mul_b", 64'(mul_b), 64'(eb));
    if (after == 0) vv[g] = 1'b0;
    else if (after == 2) begin va[g] = rand_fp(); vb[g] = rand_fp(); end
    if (churn) begin
      for (int k = 0; k < N; k++) begin
        if (k != g && $urandom_range(0, 2) == 0) begin
          vv[k] = ~vv[k];
          va[k] = rand_fp();
          vb[k] = rand_fp();
        end
      end
    end
    apply();
    resp_ready = 4'($urandom) & ~4'(1 << g);
    cyc  = 1;
    seen = 1'b0;
    for (int t = 0; t < 4*L + 8 && !seen; t++) begin
      @(negedge clk);
      if (resp_valid != '0) seen = 1'b1;
      else begin
        check("ready_in_wait", 64'(req_ready), 0);
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("resp_seen", 64'(seen), 1);
    check("resp_latency", 64'(cyc), 64'(L + 1));
    check("resp_valid", 64'(resp_valid), 64'(1 << g));
    check("resp_data", 64'(resp_data), 64'(fmul(ea, eb)));
    check("mul_a_stable", 64'(mul_a), 64'(ea));
    got = resp_data;
    for (int h = 0; h < hold; h++) begin
      resp_ready = 4'($urandom) & ~4'(1 << g);
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_valid", 64'(resp_valid), 64'(1 << g));
      check("hold_data", 64'(resp_data), 64'(fmul(ea, eb)));
      check("hold_no_grant", 64'(req_ready), 0);
    end
    resp_ready = 4'($urandom) | 4'(1 << g);
    @(posedge clk); #1;
    resp_ready = '0;
    ptr = (g + 1) % N;
    check("busy_after_resp", 64'(busy), 0);
    check("valid_after_resp", 64'(resp_valid), 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ptr = 0;
  endtask

  logic [W-1:0] got;
  int           g0;

  initial begin
    rst        = 1'b1;
    resp_ready = '0;
    ptr        = 0;
    for (int k = 0; k < N; k++) begin va[k] = rand_fp(); vb[k] = rand_fp(); end
    vv = '1;
    apply();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_resp_valid", 64'(resp_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mul_a", 64'(mul_a), 0);
    check("rst_mul_b", 64'(mul_b), 0);
    check("rst_grant", 64'(grant_id), 0);
    check("rst_resp_data", 64'(resp_data), 0);
    check("rst_busy_after", 64'(busy), 0);

    // Single requester 0, directed operands.
    vv = 4'b0001; va[0] = 32'hC0000000; vb[0] = 32'h3E000000;
    apply();
    run_txn(0, 0, 1'b0, got);
    check("req0_product", 64'(got), 64'hBE800000);

    // No requests: stay idle, operands hold.
    vv = '0;
    apply();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("idle_ready", 64'(req_ready), 0);
      check("idle_busy", 64'(busy), 0);
      check("idle_mul_a", 64'(mul_a), 64'h C0000000);
      @(posedge clk); #1;
    end

    // All four continuously valid from reset: rotation 0,1,2,3,0.
    pulse_reset();
    for (int k = 0; k < N; k++) begin va[k] = 32'h40600000; vb[k] = 32'h425D0000; end
    vv = '1;
    apply();
    for (int i = 0; i < N + 1; i++) begin
      run_txn(0, 1, 1'b0, got);
      check("all_product", 64'(got), 64'h43416000);
    end

    // Requester 2 stalls its response 5 cycles; requester 3 waits, then wins.
    vv = 4'b0100; va[2] = rand_fp(); vb[2] = rand_fp();
    apply();
    ptr = 1;
    run_txn(5, 0, 1'b0, got);
    vv = 4'b1000; va[3] = rand_fp(); vb[3] = rand_fp();
    apply();
    run_txn(0, 0, 1'b0, got);

    // NaN operands pass through bit-exact from the multiplier.
    vv = 4'b0010; va[1] = 32'hFFFFFFFF; vb[1] = 32'h00000000;
    apply();
    run_txn(0, 0, 1'b0, got);
    check("nan_passthru", 64'(got), 64'hFFFFFFFF);

    // Reset during WAIT cycle 3 discards the operation.
    vv = 4'b0100; va[2] = rand_fp(); vb[2] = rand_fp();
    apply();
    g0 = rr_pick();
    @(posedge clk); #1;
    check("wrst_grant", 64'(grant_id), 64'(g0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin va[k] = rand_fp(); vb[k] = rand_fp(); end
    vv = '1;
    apply();
    @(negedge clk);
    check("wrst_busy_during", 64'(busy), 0);
    check("wrst_valid_during", 64'(resp_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ptr = 0;
    check("wrst_busy", 64'(busy), 0);
    check("wrst_mul_a", 64'(mul_a), 0);
    check("wrst_grant0", 64'(grant_id), 0);
    check("wrst_resp_data", 64'(resp_data), 0);
    run_txn(0, 0, 1'b0, got);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        vv = '0;
        apply();
        @(negedge clk);
        check("rand_idle_ready", 64'(req_ready), 0);
        @(posedge clk); #1;
      end
      if (vv == '0) begin
        vv[$urandom_range(0, N-1)] = 1'b1;
        for (int k = 0; k < N; k++) begin va[k] = rand_fp(); vb[k] = rand_fp(); end
      end
      apply();
      run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b1, got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_mult_arbiter.md
FP_MULT_ARBITER -- requirements
Module: fp_mult_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, IEEE-754 single operand/result width.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter LATENCY, default 8, cycles the multiplier needs from stable operands to valid result (>=1).
REQ-004 SHALL have port i_clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port i_req_valid, input, NUM_REQ, per-requester operation request.
REQ-007 SHALL have port i_req_a, input, NUM_REQ*WIDTH, operand A; requester k in bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port i_req_b, input, NUM_REQ*WIDTH, operand B; same packing.
REQ-009 SHALL have port o_req_ready, output, NUM_REQ, one-hot acceptance of the granted requester.
REQ-010 SHALL have port o_resp_valid, output, NUM_REQ, one-hot result-available flag.
REQ-011 SHALL have port o_resp_data, output, WIDTH, product for the requester flagged in o_resp_valid.
REQ-012 SHALL have port i_resp_ready, input, NUM_REQ, per-requester result acceptance.
REQ-013 SHALL have ports o_mul_a, o_mul_b, output, WIDTH each, registered operands driven to the shared multiplier.
REQ-014 SHALL have port i_mul_res, input, WIDTH, multiplier result.
REQ-015 SHALL have port o_grant_id, output, clog2(NUM_REQ), index of the requester currently owning the multiplier.
REQ-016 SHALL have port o_busy, output, 1, high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-018 IDLE: if any i_req_valid, SHALL select winner g by round-robin, searching from pointer p upward with wrap-around; o_req_ready[g] asserted combinationally that cycle only.
REQ-019 Request handshake = i_req_valid[g] & o_req_ready[g]; at that edge SHALL load o_mul_a/o_mul_b from requester g, o_grant_id<=g, counter<=LATENCY, state<=WAIT.
REQ-020 IDLE with no valid: SHALL stay in IDLE, all ready/valid low, o_mul_a/o_mul_b hold.
REQ-021 WAIT: counter SHALL decrement each cycle; in the cycle where counter==1, the edge SHALL capture i_mul_res into o_resp_data and go to RESP; WAIT lasts exactly LATENCY cycles.
REQ-022 o_mul_a/o_mul_b SHALL stay constant through WAIT and RESP.
REQ-023 RESP: o_resp_valid[g]=1 (registered), o_resp_data stable; on i_resp_ready[g]=1 SHALL go to IDLE and set p<=(g+1) mod NUM_REQ.
REQ-024 i_resp_ready of non-granted requesters and all i_req_valid SHALL be ignored outside IDLE.
REQ-025 A request deasserted after its handshake SHALL not affect the in-flight operation.
REQ-026 Minimum transaction SHALL be 1 (IDLE) + LATENCY (WAIT) + 1 (RESP) cycles; the next grant can occur in the IDLE cycle right after response handshake.
REQ-027 With a single persistent requester, it SHALL win every arbitration (no idle gaps beyond REQ-026).
REQ-028 With all requesters continuously valid, grants SHALL rotate 0,1,...,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 transactions.
REQ-029 Block SHALL not inspect or modify data (NaN/Inf/subnormal pass through unchanged from i_mul_res).

Reset
REQ-030 On i_rst=1 at an edge SHALL go to IDLE, p<=0, counter<=0, o_grant_id<=0, o_mul_a<=0, o_mul_b<=0, o_resp_data<=0; o_resp_valid, o_req_ready, o_busy low while reset is asserted.
REQ-031 Reset in WAIT or RESP SHALL discard the in-flight operation; no o_resp_valid is produced for it afterwards.

Verification
REQ-032 Bench drives i_mul_res from a fixed-LATENCY behavioural multiplier model (and separately from the team's floating multiplier with LATENCY set to its settle time).
REQ-033 Req 0 only: A=0xC0000000, B=0x3E000000 -> o_req_ready[0] same cycle, o_resp_valid[0] after exactly LATENCY+1 cycles, o_resp_data=0xBE800000.
REQ-034 All four valid from reset, requester k: A=0x40600000, B=0x425D0000 -> grant order 0,1,2,3, each o_resp_data=0x43416000, resp ready tied high, grants spaced LATENCY+2 cycles.
REQ-035 Req 2 in RESP, i_resp_ready[2] held low 5 cycles -> o_resp_valid[2] and data held 5 cycles, no new grant; release -> IDLE next edge, next grant goes to 3 if valid.
REQ-036 i_rst pulsed in WAIT cycle 3 of a transaction -> next cycle IDLE, o_busy=0, outputs zero, no response for that request, next grant to requester 0.
REQ-037 NaN operands 0xFFFFFFFF x 0x00000000 from req 1 -> o_resp_data equals multiplier output bit-exact (0xFFFFFFFF).
